// File: rtl/fetch_decode_pipe_if.sv
// Fetch/decode bundle: hazard and decode-resolved controls, imem port, IF/ID outputs.
// Latency: pure wiring, no state.
// Backpressure: stall_f/stall_d carry the hazard unit's hold requests into fetch.
interface fetch_decode_pipe_if;
  logic        stall_f;
  logic        stall_d;
  logic        pc_src_d;
  logic [31:0] branch_target_d;
  logic [1:0]  sig_jump_d;
  logic [31:0] jump_target_d;
  logic [31:0] jr_target_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        redirect_d;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Fetch stage side
  modport slave (
    input  stall_f, stall_d, pc_src_d, branch_target_d, sig_jump_d,
           jump_target_d, jr_target_d, imem_rdata,
    output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, redirect_d,
           stall_cnt, flush_cnt
  );

  // Hazard unit / decode / instruction memory side
  modport master (
    output stall_f, stall_d, pc_src_d, branch_target_d, sig_jump_d,
           jump_target_d, jr_target_d, imem_rdata,
    input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, redirect_d,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// Fetch stage + IF/ID register of the 5-stage MIPS core; optional stats counters under FETCH_STATS_EN.
// Latency: word read at pc_f in cycle n appears on instr_d in cycle n+1; redirect_d is combinational.
// Backpressure: stall_f/stall_d hold PC and IF/ID; a decode redirect overrides stall_f but is blocked by stall_d.
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_decode_pipe_if.slave   bus
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_hold_pc;

  // Redirect decision and target select; decode operands are stale while stall_d is up
  always_comb begin
    w_redirect = (bus.pc_src_d | (bus.sig_jump_d == 2'b01) | (bus.sig_jump_d == 2'b10))
                 & ~bus.stall_d;
    case (bus.sig_jump_d)
      2'b10:   w_target_raw = bus.jr_target_d;
      2'b01:   w_target_raw = bus.jump_target_d;
      default: w_target_raw = bus.branch_target_d;
    endcase
    w_target   = {w_target_raw[31:2], 2'b00};
    // Natural 32-bit wrap takes 0xFFFF_FFFC to 0
    w_pc_plus4 = r_pc + 32'd4;
    // stall_d alone also holds the PC so the word behind a held IF/ID is not skipped
    w_hold_pc  = bus.stall_f | bus.stall_d;
  end

  // Program counter: redirect wins over any hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (!w_hold_pc) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register: squash on redirect (no delay slot), hold on stall_d, else capture fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (!bus.stall_d) begin
      r_instr    <= bus.imem_rdata;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating stall/redirect counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_hold_pc && !w_redirect && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

  assign bus.imem_addr  = r_pc;
  assign bus.pc_f       = r_pc;
  assign bus.instr_d    = r_instr;
  assign bus.pc_plus4_d = r_pc_plus4;
  assign bus.valid_d    = r_valid;
  assign bus.redirect_d = w_redirect;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Testbench for fetch_decode_pipe: directed scenarios then random stimulus against a behavioural model.
// Latency: expected IF/ID/PC state is queued per edge and compared one step after that edge.
// Backpressure: random stall_f/stall_d patterns, including stall_d without stall_f.
module tb_fetch_decode_pipe;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_decode_pipe_if bus();

  fetch_decode_pipe #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: architectural view of fetch + IF/ID
  logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fc;
  logic        m_valid;

  function automatic logic [31:0] cnt_view(input logic [31:0] c);
`ifdef FETCH_STATS_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
    m_sc = 32'd0; m_fc = 32'd0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    bus.pc_f,             RESET_PC);
    chk({tag, "_instr"}, bus.instr_d,          NOP_INSTR);
    chk({tag, "_pc4"},   bus.pc_plus4_d,       32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid_d}, 32'd0);
    chk({tag, "_scnt"},  bus.stall_cnt,        32'd0);
    chk({tag, "_fcnt"},  bus.flush_cnt,        32'd0);
  endtask

  // One clock of stimulus: called at a negedge, returns at the next negedge
  task automatic step(input logic sf, input logic sd, input logic ps,
                      input logic [31:0] bt, input logic [1:0] sj,
                      input logic [31:0] jt, input logic [31:0] jr);
    logic        redir;
    logic [31:0] tgt;
    exp_t        e;
    bus.stall_f = sf; bus.stall_d = sd; bus.pc_src_d = ps;
    bus.branch_target_d = bt; bus.sig_jump_d = sj;
    bus.jump_target_d = jt; bus.jr_target_d = jr;
    #1;
    redir = (ps || sj == 2'd1 || sj == 2'd2) && !sd;
    chk("redirect_d", {31'd0, bus.redirect_d}, {31'd0, redir});
    chk("imem_addr",  bus.imem_addr, m_pc);
    tgt = (sj == 2'd2) ? jr : (sj == 2'd1) ? jt : bt;
    tgt = tgt - (tgt % 4);
    if (redir) begin
      m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
      m_pc = tgt;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end else begin
      if (!sd) begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1;
      end
      if (sf || sd) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.sc = cnt_view(m_sc); e.fc = cnt_view(m_fc);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);
  endtask

  // Monitor: the post-edge state is the DUT's output for that cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_f",       bus.pc_f,             e.pc);
        chk("instr_d",    bus.instr_d,          e.instr);
        chk("pc_plus4_d", bus.pc_plus4_d,       e.pc4);
        chk("valid_d",    {31'd0, bus.valid_d}, {31'd0, e.valid});
        chk("stall_cnt",  bus.stall_cnt,        e.sc);
        chk("flush_cnt",  bus.flush_cnt,        e.fc);
      end
    end
  end

  function automatic logic [31:0] rnd_tgt();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return 32'h0040_0000 + ($urandom & 32'h0000_0FFF);
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.stall_f = 1'b0; bus.stall_d = 1'b0; bus.pc_src_d = 1'b0;
    bus.branch_target_d = 32'h0; bus.sig_jump_d = 2'b00;
    bus.jump_target_d = 32'h0; bus.jr_target_d = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Reset release: first edge captures the word at RESET_PC
    idle();
    chk("t1_instr", bus.instr_d,    32'h2008_0005);
    chk("t1_pc4",   bus.pc_plus4_d, 32'h0040_0004);
    chk("t1_pc",    bus.pc_f,       32'h0040_0004);

    // Stall three edges at 0x00400008
    idle();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);
    chk("t2_hold_pc",  bus.pc_f,       32'h0040_0008);
    chk("t2_hold_pc4", bus.pc_plus4_d, 32'h0040_0008);
    idle();
    chk("t2_release", bus.pc_f, 32'h0040_000C);

    // Taken branch squashes the fetched word
    step(1'b0, 1'b0, 1'b1, 32'h0040_0040, 2'b00, 32'h0, 32'h0);
    chk("t3_pc",    bus.pc_f,             32'h0040_0040);
    chk("t3_valid", {31'd0, bus.valid_d}, 32'd0);

    // jr blocked by stall_d, then taken with an unaligned target
    step(1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 32'h0, 32'h0040_0100);
    chk("t4_held", bus.pc_f, 32'h0040_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 32'h0040_0103);
    chk("t4_jr", bus.pc_f, 32'h0040_0100);
    chk("t6_scnt", bus.stall_cnt, cnt_view(32'd4));
    chk("t6_fcnt", bus.flush_cnt, cnt_view(32'd2));

    // Jump beats branch; wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'h0040_0040, 2'b01, 32'h0040_0200, 32'h0);
    chk("t5_prio", bus.pc_f, 32'h0040_0200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 32'hFFFF_FFFF);
    chk("t5_top", bus.pc_f, 32'hFFFF_FFFC);
    idle();
    chk("t5_wrap_pc",  bus.pc_f,       32'h0);
    chk("t5_wrap_pc4", bus.pc_plus4_d, 32'h0);

    // Reserved jump code behaves as none, branch still honoured
    step(1'b0, 1'b0, 1'b1, 32'h0040_0080, 2'b11, 32'h0040_0300, 32'h0040_0400);
    chk("t7_res", bus.pc_f, 32'h0040_0080);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic sf, sd, ps;
      logic [1:0] sj;
      sf = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0);
      ps = ($urandom_range(0, 7) == 0);
      sj = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(sf, sd, ps, rnd_tgt(), sj, rnd_tgt(), $urandom);
    end

    // Asynchronous reset in the middle of a stall with a blocked redirect pending
    bus.stall_f = 1'b1; bus.stall_d = 1'b1; bus.pc_src_d = 1'b1;
    bus.branch_target_d = 32'h0040_0500;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_state("rst_stall");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rst_stall_pc", bus.pc_f, 32'h0040_0004);

    // Asynchronous reset while a redirect is being presented
    bus.pc_src_d = 1'b1; bus.branch_target_d = 32'h0040_0600;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_state("rst_redir");
    model_reset();
    @(negedge clk);
    bus.pc_src_d = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("rst_redir_instr", bus.instr_d, 32'h2008_0005);
    repeat (5) idle();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain_left", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
